// File: rtl/rle_pkg.sv
// rle_pkg: FSM state encoding and default constants shared by the RLE encoder files.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCUM    = 3'd1,
    EMIT_ESC = 3'd2,
    EMIT_CNT = 3'd3,
    EMIT_SYM = 3'd4,
    EMIT_LIT = 3'd5
  } rle_state_e;

  localparam logic [7:0] ESC_DEFAULT     = 8'h1B;
  localparam int         MIN_RUN_DEFAULT = 3;

endpackage

// File: rtl/rle_sync_fifo.sv
// rle_sync_fifo: single-clock input buffer with wrap-around pointers and an occupancy counter.
module rle_sync_fifo
  import rle_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        data_clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // storage array; contents are qualified by the pointers so they need no reset
  always_ff @(posedge data_clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rle_encoder_fifo.sv
// rle_encoder_fifo: buffered run-length encoder. Long runs and any ESC symbol leave as
// ESC/count/symbol triples; shorter runs leave as repeated literals.
module rle_encoder_fifo
  import rle_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 16,
  parameter int                CNT_W      = 8,
  parameter logic [DATA_W-1:0] ESC        = DATA_W'(ESC_DEFAULT),
  parameter int                MIN_RUN    = MIN_RUN_DEFAULT
) (
  input  logic                        data_clk,
  input  logic                        reset_n,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  input  logic                        flush,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  localparam int               CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] MAX_RUN   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_RUN   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);

  rle_state_e        state_r;
  logic [DATA_W-1:0] cur_sym_r;
  logic [CNT_W-1:0]  run_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              in_ready_r;

  logic [DATA_W-1:0] head_s;
  logic              push_s;
  logic              pop_s;
  logic              close_s;
  logic              escape_s;
  logic              full_s;
  logic              empty_s;
  logic [CW-1:0]     fifo_cnt_s;
  logic [CW-1:0]     cnt_next_s;

  assign push_s     = data_in_valid && in_ready_r && !full_s;
  assign escape_s   = (run_r >= MIN_RUN_C) || (cur_sym_r == ESC);
  assign cnt_next_s = fifo_cnt_s + CW'(push_s) - CW'(pop_s);

  rle_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .data_clk (data_clk),
    .reset_n  (reset_n),
    .push     (push_s),
    .wr_data  (data_in),
    .pop      (pop_s),
    .rd_data  (head_s),
    .full     (full_s),
    .empty    (empty_s),
    .count    (fifo_cnt_s)
  );

  // pop and run-close decisions; a run left open with an empty FIFO waits for more data or flush
  always_comb begin
    pop_s   = 1'b0;
    close_s = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s = !empty_s;
      end
      ACCUM: begin
        if (run_r == MAX_RUN) begin
          close_s = 1'b1;
        end else if (!empty_s) begin
          if (head_s == cur_sym_r) begin
            pop_s = 1'b1;
          end else begin
            close_s = 1'b1;
          end
        end else begin
          close_s = flush;
        end
      end
      default: begin
        pop_s   = 1'b0;
        close_s = 1'b0;
      end
    endcase
  end

  // registered not-full flag; stays low through reset and rises on the first edge after it
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_r <= 1'b0;
    end else begin
      in_ready_r <= (cnt_next_s != DEPTH_C);
    end
  end

  // encoder FSM with registered output word; each EMIT state advances only on acceptance
  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cur_sym_r   <= {DATA_W{1'b0}};
      run_r       <= {CNT_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!empty_s) begin
            cur_sym_r <= head_s;
            run_r     <= ONE_RUN;
            state_r   <= ACCUM;
          end
        end
        ACCUM: begin
          if (close_s) begin
            out_valid_r <= 1'b1;
            if (escape_s) begin
              out_data_r <= ESC;
              state_r    <= EMIT_ESC;
            end else begin
              out_data_r <= cur_sym_r;
              state_r    <= EMIT_LIT;
            end
          end else if (pop_s) begin
            run_r <= run_r + ONE_RUN;
          end
        end
        EMIT_ESC: begin
          if (data_out_ready) begin
            out_data_r <= DATA_W'(run_r);
            state_r    <= EMIT_CNT;
          end
        end
        EMIT_CNT: begin
          if (data_out_ready) begin
            out_data_r <= cur_sym_r;
            state_r    <= EMIT_SYM;
          end
        end
        EMIT_SYM: begin
          if (data_out_ready) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        EMIT_LIT: begin
          // run_r counts down the literal copies still to be sent
          if (data_out_ready) begin
            if (run_r == ONE_RUN) begin
              out_data_r  <= {DATA_W{1'b0}};
              out_valid_r <= 1'b0;
              state_r     <= IDLE;
            end else begin
              run_r <= run_r - ONE_RUN;
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign data_out       = out_data_r;
  assign data_out_valid = out_valid_r;
  assign data_in_ready  = in_ready_r;
  assign fifo_count     = fifo_cnt_s;
  assign busy           = (state_r != IDLE) || !empty_s;

endmodule

// File: tb/tb_rle_encoder_fifo.sv
// tb_rle_encoder_fifo: table vectors, directed corner sequences and random streams checked
// against a run-grouping reference model.
`timescale 1ns/1ps
module tb_rle_encoder_fifo;

  logic       data_clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       flush;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic [4:0] fifo_count;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] in_q  [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] alpha [6];
  bit         held_v = 1'b0;
  logic [7:0] held_d = 8'h00;
  bit         in_xfer = 1'b0;

  typedef struct packed {
    logic [3:0]       n_in;
    logic [0:7][7:0]  in_s;
    logic [3:0]       n_out;
    logic [0:7][7:0]  out_s;
  } vec_t;
  vec_t vecs [6];

  rle_encoder_fifo dut (
    .data_clk       (data_clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .flush          (flush),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_count     (fifo_count),
    .busy           (busy)
  );

  always #5 data_clk = ~data_clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // one clock: sample outputs on the falling edge, then step past the rising edge
  task automatic tick();
    @(negedge data_clk);
    if (held_v) begin
      total++;
      if (!data_out_valid || data_out !== held_d) begin
        bad++;
        $display("FAIL hold_stable got v=%0b d=%02h want v=1 d=%02h", data_out_valid, data_out, held_d);
      end
    end
    if (data_out_valid && data_out_ready) got_q.push_back(data_out);
    held_v  = data_out_valid && !data_out_ready;
    held_d  = data_out;
    in_xfer = data_in_valid && data_in_ready;
    @(posedge data_clk);
    #1;
  endtask

  task automatic drive_inputs(input int gap_pct, input int bp_pct, input int hold);
    int idx = 0;
    int c = 0;
    while (idx < in_q.size() && c < 20000) begin
      if (hold > 0 && c == hold) begin
        check("bp_full_count", 32'(fifo_count), 32'd16);
        check("bp_in_ready_low", 32'(data_in_ready), 32'd0);
      end
      data_in        = in_q[idx];
      data_in_valid  = (c < hold) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      data_out_ready = (c < hold) ? 1'b0 : ($urandom_range(99) >= bp_pct);
      tick();
      if (in_xfer) idx++;
      c++;
    end
    data_in_valid = 1'b0;
    if (idx < in_q.size()) check("drive_timeout", 32'(idx), 32'(in_q.size()));
  endtask

  task automatic finish_flush(input int bp_pct);
    bit done = 1'b0;
    flush         = 1'b1;
    data_in_valid = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      data_out_ready = ($urandom_range(99) >= bp_pct);
      tick();
      if (!busy && !data_out_valid) done = 1'b1;
    end
    flush          = 1'b0;
    data_out_ready = 1'b1;
    if (!done) check("flush_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_out(input string name);
    int n;
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s_len got=%0d want=%0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_word%0d got=%02h want=%02h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  // reference: group maximal runs (capped at 255), escape long runs and any ESC symbol
  task automatic model_encode();
    int i = 0;
    int r;
    logic [7:0] s;
    exp_q.delete();
    while (i < in_q.size()) begin
      s = in_q[i];
      r = 1;
      while (i + r < in_q.size() && in_q[i+r] == s && r < 255) r++;
      if (r >= 3 || s == 8'h1B) begin
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'(r));
        exp_q.push_back(s);
      end else begin
        for (int k = 0; k < r; k++) exp_q.push_back(s);
      end
      i += r;
    end
  endtask

  task automatic gen_random(input int n_runs, input int max_len, input bit long_ok);
    logic [7:0] s;
    int len;
    in_q.delete();
    for (int j = 0; j < n_runs; j++) begin
      s = alpha[$urandom_range(5)];
      if (long_ok && $urandom_range(7) == 0) len = $urandom_range(240, 270);
      else len = $urandom_range(1, max_len);
      for (int k = 0; k < len; k++) in_q.push_back(s);
    end
  endtask

  task automatic run_case(input string name, input int gap_pct, input int bp_pct);
    got_q.delete();
    drive_inputs(gap_pct, bp_pct, 0);
    finish_flush(bp_pct);
    compare_out(name);
  endtask

  initial begin
    alpha = '{8'h1B, 8'h41, 8'h42, 8'h43, 8'h00, 8'hFF};
    vecs[0].n_in = 4'd5; vecs[0].in_s  = {8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00};
    vecs[0].n_out = 4'd4; vecs[0].out_s = {8'h1B, 8'h04, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].n_in = 4'd3; vecs[1].in_s  = {8'h41, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].n_out = 4'd3; vecs[1].out_s = {8'h41, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].n_in = 4'd1; vecs[2].in_s  = {8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].n_out = 4'd3; vecs[2].out_s = {8'h1B, 8'h01, 8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].n_in = 4'd3; vecs[3].in_s  = {8'h41, 8'h41, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].n_out = 4'd3; vecs[3].out_s = {8'h1B, 8'h03, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].n_in = 4'd4; vecs[4].in_s  = {8'h1B, 8'h1B, 8'h43, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].n_out = 4'd5; vecs[4].out_s = {8'h1B, 8'h02, 8'h1B, 8'h43, 8'h43, 8'h00, 8'h00, 8'h00};
    vecs[5].n_in = 4'd8; vecs[5].in_s  = {8'h10, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30};
    vecs[5].n_out = 4'd5; vecs[5].out_s = {8'h10, 8'h1B, 8'h06, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00};

    reset_n        = 1'b0;
    data_in        = 8'h00;
    data_in_valid  = 1'b0;
    flush          = 1'b0;
    data_out_ready = 1'b1;

    // reset state
    #3;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_out_valid", 32'(data_out_valid), 32'h0);
    check("rst_in_ready", 32'(data_in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    repeat (2) @(posedge data_clk);
    #1;
    check("rst_in_ready_held", 32'(data_in_ready), 32'h0);
    reset_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(data_in_ready), 32'h0);
    tick();
    check("ready_after_edge", 32'(data_in_ready), 32'h1);

    // table vectors with the output always ready
    for (int v = 0; v < 6; v++) begin
      in_q.delete();
      exp_q.delete();
      for (int i = 0; i < int'(vecs[v].n_in); i++) in_q.push_back(vecs[v].in_s[i]);
      for (int i = 0; i < int'(vecs[v].n_out); i++) exp_q.push_back(vecs[v].out_s[i]);
      run_case($sformatf("vec%0d", v), 0, 0);
    end

    // run longer than the counter range splits at 255
    in_q.delete();
    for (int i = 0; i < 300; i++) in_q.push_back(8'h55);
    exp_q = '{8'h1B, 8'hFF, 8'h55, 8'h1B, 8'h2D, 8'h55};
    run_case("run300", 0, 0);

    // an open run with no flush produces nothing
    in_q = '{8'h41, 8'h41, 8'h41};
    exp_q = '{8'h1B, 8'h03, 8'h41};
    got_q.delete();
    drive_inputs(0, 0, 0);
    repeat (20) tick();
    check("open_run_no_output", 32'(got_q.size()), 32'd0);
    check("open_run_busy", 32'(busy), 32'd1);
    finish_flush(0);
    compare_out("open_run");

    // flush while idle and empty is ignored
    got_q.delete();
    flush = 1'b1;
    repeat (5) tick();
    flush = 1'b0;
    check("idle_flush_output", 32'(got_q.size()), 32'd0);
    check("idle_flush_busy", 32'(busy), 32'd0);

    // output stalled for 40 cycles while the input keeps streaming
    gen_random(40, 3, 1'b0);
    model_encode();
    got_q.delete();
    drive_inputs(0, 0, 40);
    finish_flush(0);
    compare_out("backpressure");

    // random streams with input gaps and output backpressure
    for (int r = 0; r < 6; r++) begin
      gen_random(14, 6, 1'b1);
      model_encode();
      run_case($sformatf("rand%0d", r), 20 * (r % 3), 25 * (r % 3));
    end

    // reset while the count word of an escape triple is on the output
    in_q = '{8'h41, 8'h41, 8'h41, 8'h41};
    got_q.delete();
    drive_inputs(0, 100, 0);
    flush = 1'b1;
    data_out_ready = 1'b0;
    for (int k = 0; k < 30 && !data_out_valid; k++) tick();
    check("mid_esc_word", 32'({data_out_valid, data_out}), 32'h11B);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    check("mid_cnt_word", 32'({data_out_valid, data_out}), 32'h104);
    reset_n = 1'b0;
    flush   = 1'b0;
    held_v  = 1'b0;
    #1;
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_out_valid), 32'h0);
    check("mid_rst_in_ready", 32'(data_in_ready), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    @(posedge data_clk);
    #1;
    reset_n = 1'b1;
    data_out_ready = 1'b1;
    tick();
    check("mid_rst_ready_back", 32'(data_in_ready), 32'h1);
    in_q = '{8'h42, 8'h42, 8'h42};
    exp_q = '{8'h1B, 8'h03, 8'h42};
    run_case("after_reset", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
